// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline with multi-cycle
//            watchdog and saturating stall/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             ex_mc_op,
    input  logic             mc_done,
    input  logic             halt_req,
    output logic             mc_start,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_flush,
    output logic             exmem_we,
    output logic             exmem_flush,
    output logic             halted,
    output logic             mc_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // Watchdog only has to reach MC_TIMEOUT-1
    localparam int                c_wd_w    = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_HALT    = 2'd2,
        ST_ERROR   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_wd_w-1:0]   r_wdog;
    logic                r_mc_timeout;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_flush_count;
    logic                w_br_accept;
    logic                w_wd_clr;
    logic                w_wd_inc;

    always_comb begin
        mc_start     = 1'b0;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_flush   = 1'b0;
        exmem_we     = 1'b1;
        exmem_flush  = 1'b0;
        halted       = 1'b0;
        w_state_next = r_state;
        w_br_accept  = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_inc     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    w_br_accept = 1'b1;
                end else if (ex_mc_op) begin
                    mc_start     = 1'b1;
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_flush  = 1'b1;
                    w_wd_clr     = 1'b1;
                    w_state_next = ST_MC_WAIT;
                end else if (load_use_stall) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    idex_flush = 1'b1;
                end else if (halt_req) begin
                    w_state_next = ST_HALT;
                end
            end

            ST_MC_WAIT: begin
                // mc_done lets the whole pipe advance with the result this cycle
                if (mc_done) begin
                    w_state_next = halt_req ? ST_HALT : ST_RUN;
                end else begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_we     = 1'b0;
                    exmem_flush = 1'b1;
                    w_wd_inc    = 1'b1;
                    if (r_wdog == c_wd_last) begin
                        w_state_next = ST_ERROR;
                    end
                end
            end

            ST_HALT: begin
                halted     = 1'b1;
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                if (branch_taken) begin
                    // Redirect target is still captured while the back end drains
                    pc_we        = 1'b1;
                    ifid_flush   = 1'b1;
                    w_br_accept  = 1'b1;
                    w_state_next = halt_req ? ST_HALT : ST_RUN;
                end else if (ex_mc_op) begin
                    mc_start     = 1'b1;
                    idex_we      = 1'b0;
                    idex_flush   = 1'b0;
                    exmem_flush  = 1'b1;
                    w_wd_clr     = 1'b1;
                    w_state_next = ST_MC_WAIT;
                end else if (!halt_req) begin
                    w_state_next = ST_RUN;
                end
            end

            ST_ERROR: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
            end

            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        if (rst) begin
            mc_start     = 1'b0;
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            ifid_flush   = 1'b1;
            idex_we      = 1'b0;
            idex_flush   = 1'b1;
            exmem_we     = 1'b0;
            exmem_flush  = 1'b1;
            halted       = 1'b0;
            w_br_accept  = 1'b0;
            w_wd_clr     = 1'b0;
            w_wd_inc     = 1'b0;
            w_state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_wdog         <= '0;
            r_mc_timeout   <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_wd_clr) begin
                r_wdog <= '0;
            end else if (w_wd_inc) begin
                r_wdog <= r_wdog + 1'b1;
            end

            if (w_state_next == ST_ERROR) begin
                r_mc_timeout <= 1'b1;
            end

            if (!pc_we && (r_stall_cycles != c_cnt_max)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end

            if (w_br_accept && (r_flush_count != c_cnt_max)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign mc_timeout   = r_mc_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Takes the hazard unit's load-use stall, the EX-stage branch redirect, the multi-cycle EX unit (mul/div) start/done handshake and an external halt request.
- Drives per-stage register write-enables and bubble/flush controls.
- Provides a multi-cycle watchdog and saturating stall/flush performance counters.

Parameters:
- MC_TIMEOUT, 64: max cycles in MC_WAIT without mc_done before entering ERROR (≥2).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- load_use_stall  in  1  load-use hazard from hazard unit
- branch_taken  in  1  EX-stage taken branch/jump redirect
- ex_mc_op  in  1  instruction in EX is multi-cycle
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
- halt_req  in  1  level halt request
- mc_start  out  1  1-cycle start pulse to multi-cycle unit
- pc_we  out  1  PC update enable
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_we  out  1  ID/EX write enable
- idex_flush  out  1  ID/EX loads bubble
- exmem_we  out  1  EX/MEM write enable
- exmem_flush  out  1  EX/MEM loads bubble
- halted  out  1  high while in HALT
- mc_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0 (rst excluded)
- flush_count  out  CNT_W  saturating count of accepted branch redirects

Behaviour:
- Control outputs are combinational from state and inputs. State, counters and mc_timeout are registered.
- While rst=1: all *_we=0, all *_flush=1, mc_start=0, halted=0. Next state RUN, counters=0, mc_timeout=0.
- States: RUN, MC_WAIT, HALT, ERROR.
- RUN default (no events): pc_we=ifid_we=idex_we=exmem_we=1, flushes=0, mc_start=0.
- RUN priority (highest first):
  - 1. branch_taken: pc_we=1, ifid_flush=1, idex_flush=1. load_use_stall and ex_mc_op are ignored. flush_count+1.
  - 2. ex_mc_op: mc_start=1, pc_we=ifid_we=idex_we=0, exmem_flush=1. Next state MC_WAIT, watchdog=0.
  - 3. load_use_stall: pc_we=ifid_we=0, idex_flush=1 (idex_we=1), exmem_we=1.
  - 4. halt_req: default outputs this cycle, next state HALT.
- MC_WAIT:
  - Outputs: pc_we=ifid_we=idex_we=0, exmem_we=1, exmem_flush=1. branch_taken, load_use_stall and halt_req have no effect.
  - mc_done=1: default RUN outputs this cycle (result captured, pipeline advances). Next state HALT if halt_req=1, else RUN.
  - Watchdog: increments each MC_WAIT cycle without mc_done. If it equals MC_TIMEOUT-1 and mc_done=0, next state ERROR. mc_done in that same cycle wins.
- HALT:
  - Outputs: halted=1, pc_we=ifid_we=0, idex_we=1, idex_flush=1, exmem_we=1; the back end drains.
  - branch_taken in HALT: additionally pc_we=1 and ifid_flush=1 (target captured), flush_count+1.
  - ex_mc_op in HALT: same as RUN case 2 (mc_start, go to MC_WAIT).
  - halt_req=0 (and no ex_mc_op): next state RUN.
- ERROR: all *_we=0, all flushes=0, mc_start=0, mc_timeout=1. Exit only via rst.
- mc_start is never asserted in two consecutive cycles.
- Both counters saturate at all-ones. stall_cycles counts every non-reset cycle with pc_we=0, including HALT and ERROR.

Test Plan:
- rst held 3 cycles → enables 0, flushes 1, counters 0. Release rst with idle inputs → all *_we=1, flushes 0.
- RUN, load_use_stall for 1 cycle → that cycle pc_we=0, ifid_we=0, idex_flush=1, exmem_we=1. stall_cycles=1.
- ex_mc_op at T0, mc_done at T5 → mc_start=1 only at T0. exmem_flush=1 for T0–T4. pc_we=1 at T5, state RUN at T6. stall_cycles +5.
- MC_TIMEOUT=8, ex_mc_op with no mc_done → ERROR after 8 MC_WAIT cycles. mc_timeout=1, all we=0, persists until rst. Same run with mc_done on the 8th MC_WAIT cycle → no error.
- branch_taken and load_use_stall in the same cycle → pc_we=1, ifid_flush=1, idex_flush=1. flush_count+1, stall_cycles unchanged.
- halt_req raised during MC_WAIT → halted=0 until mc_done, HALT the next cycle (halted=1, pc_we=0). halt_req dropped → RUN one cycle later.
